// File: rtl/life_pkg.sv
// life_pkg: shared types for the Conway life engine.
//   N         board dimension (rows and columns 0..N-1)
//   ROW_W     width of a row index
//   row_t     one board row, bit c = column c, 1 = alive
//   board_t   whole board, [row][col]
//   state_t   engine FSM states
package life_pkg;

    localparam int N     = 16;
    localparam int ROW_W = $clog2(N);

    typedef logic [N-1:0]          row_t;
    typedef logic [N-1:0][N-1:0]   board_t;
    typedef logic [ROW_W-1:0]      row_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        COMMIT
    } state_t;

endpackage

// File: rtl/life_row_next.sv
// life_row_next: combinational next-generation of one board row (rule B3/S23).
//   WRAP   1 = columns wrap around, 0 = columns beyond the edge are dead
//   above  row r-1 (already edge-resolved by the caller)
//   cur    row r
//   below  row r+1 (already edge-resolved by the caller)
//   next   next-state of row r
module life_row_next
    import life_pkg::*;
#(
    parameter bit WRAP = 1'b1
) (
    input  logic [N-1:0] above,
    input  logic [N-1:0] cur,
    input  logic [N-1:0] below,
    output logic [N-1:0] next
);

    // Each row is padded with one column on each side so every cell sees a
    // full 3-wide window: pad[c] is column c-1, pad[c+1] is c, pad[c+2] is c+1.
    logic [N+1:0] pad_a;
    logic [N+1:0] pad_c;
    logic [N+1:0] pad_b;

    assign pad_a = WRAP ? {above[0], above, above[N-1]} : {1'b0, above, 1'b0};
    assign pad_c = WRAP ? {cur[0],   cur,   cur[N-1]}   : {1'b0, cur,   1'b0};
    assign pad_b = WRAP ? {below[0], below, below[N-1]} : {1'b0, below, 1'b0};

    for (genvar c = 0; c < N; c++) begin : g_cell
        logic [3:0] window;
        logic [3:0] count;

        // Sum the whole 3x3 window, then remove the cell itself.
        assign window = 4'(pad_a[c]) + 4'(pad_a[c+1]) + 4'(pad_a[c+2])
                      + 4'(pad_c[c]) + 4'(pad_c[c+1]) + 4'(pad_c[c+2])
                      + 4'(pad_b[c]) + 4'(pad_b[c+1]) + 4'(pad_b[c+2]);
        assign count  = window - 4'(cur[c]);

        assign next[c] = (count == 4'd3) | (cur[c] & (count == 4'd2));
    end

endmodule

// File: rtl/life_engine.sv
// life_engine: 16x16 Game-of-Life generation engine.
// Holds the live board, advances it one generation on a step pulse or on a
// free-running tick while run=1. One row is computed per clock into a shadow
// buffer and the whole board is committed at once.
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   userInput   seed board from the cell editor, [row][col]
//   load        copy userInput into the live board (highest priority)
//   run         level; auto-step every TICK_DIV cycles
//   step        single-cycle pulse requesting one generation
//   board       current live generation, [row][col]
//   generation  generations since last load/reset, wraps at 16 bits
//   busy        high while a generation is being computed
module life_engine
    import life_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000,
    parameter bit WRAP     = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0][N-1:0]   userInput,
    input  logic                  load,
    input  logic                  run,
    input  logic                  step,
    output logic [N-1:0][N-1:0]   board,
    output logic [15:0]           generation,
    output logic                  busy
);

    localparam int       TICK_W   = $clog2(TICK_DIV);
    localparam row_idx_t LAST_ROW = row_idx_t'(N - 1);

    state_t              state;
    state_t              next_state;
    row_idx_t            row;
    row_idx_t            row_up;
    row_idx_t            row_dn;
    logic [TICK_W-1:0]   tick_cnt;
    logic                tick;
    logic                start;
    logic                compute_en;
    logic                commit;
    row_t                above;
    row_t                below;
    row_t                next_row;
    board_t              shadow;

    assign tick   = run && (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign row_up = row - row_idx_t'(1);
    assign row_dn = row + row_idx_t'(1);

    // Neighbour rows for the row being computed; edges wrap or read as dead.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        above = '0;
        below = '0;
        if (row != '0)
            above = board[row_up];
        else if (WRAP)
            above = board[N-1];
        if (row != LAST_ROW)
            below = board[row_dn];
        else if (WRAP)
            below = board[0];
    end

    life_row_next #(.WRAP(WRAP)) u_row_next (
        .above (above),
        .cur   (board[row]),
        .below (below),
        .next  (next_row)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples the values from before this edge.
            state <= next_state;
    end

    // FSM next-state and datapath strobes; load overrides everything.
    always_comb begin
        next_state = state;
        start      = 1'b0;
        compute_en = 1'b0;
        commit     = 1'b0;
        if (load) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    // step and tick together still start just one generation
                    if (step || tick) begin
                        next_state = COMPUTE;
                        start      = 1'b1;
                    end
                end
                COMPUTE: begin
                    compute_en = 1'b1;
                    if (row == LAST_ROW)
                        next_state = COMMIT;
                end
                COMMIT: begin
                    commit     = 1'b1;
                    next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Registered outputs, row index and auto-step tick counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            board      <= '0;
            generation <= '0;
            busy       <= 1'b0;
            row        <= '0;
            tick_cnt   <= '0;
        end else begin
            if (load || !run || tick)
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + 1'b1;

            if (load) begin
                board      <= userInput;
                generation <= '0;
                busy       <= 1'b0;
                row        <= '0;
            end else if (start) begin
                row  <= '0;
                busy <= 1'b1;
            end else if (compute_en) begin
                row <= (row == LAST_ROW) ? '0 : row_dn;
            end else if (commit) begin
                board      <= shadow;
                generation <= generation + 16'd1;
                busy       <= 1'b0;
            end
        end
    end

    // NOTE: the shadow buffer is deliberately not reset; it is always fully
    // rewritten before a commit reads it, so a reset would only cost flops.
    always_ff @(posedge clk) begin
        if (compute_en)
            shadow[row] <= next_row;
    end

endmodule

// File: tb/tb_life_engine.sv
// tb_life_engine: self-checking bench for life_engine. Two instances share
// stimulus, one with toroidal edges and one with dead edges, and both are
// compared against a cell-by-cell model of the B3/S23 rule.
module tb_life_engine;
    import life_pkg::*;

    localparam int TDIV = 20;

    logic   clk = 1'b0;
    logic   reset;
    board_t userInput;
    logic   load;
    logic   run;
    logic   step;

    board_t      board_w;
    logic [15:0] gen_w;
    logic        busy_w;
    board_t      board_f;
    logic [15:0] gen_f;
    logic        busy_f;

    int vectors     = 0;
    int miscompares = 0;

    board_t      exp_w;
    board_t      exp_f;
    logic [15:0] exp_gen;

    always #5 clk = ~clk;

    life_engine #(.TICK_DIV(TDIV), .WRAP(1'b1)) dut_wrap (
        .clk        (clk),
        .reset      (reset),
        .userInput  (userInput),
        .load       (load),
        .run        (run),
        .step       (step),
        .board      (board_w),
        .generation (gen_w),
        .busy       (busy_w)
    );

    life_engine #(.TICK_DIV(TDIV), .WRAP(1'b0)) dut_flat (
        .clk        (clk),
        .reset      (reset),
        .userInput  (userInput),
        .load       (load),
        .run        (run),
        .step       (step),
        .board      (board_f),
        .generation (gen_f),
        .busy       (busy_f)
    );

    // Reference: count the eight neighbours of each cell directly.
    function automatic board_t model_gen(board_t b, bit wrap);
        board_t nb = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                int n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr;
                        int cc;
                        rr = r + dr;
                        cc = c + dc;
                        if (dr == 0 && dc == 0) continue;
                        if (wrap) begin
                            rr = (rr + N) % N;
                            cc = (cc + N) % N;
                        end else if (rr < 0 || rr >= N || cc < 0 || cc >= N) begin
                            continue;
                        end
                        if (b[rr][cc]) n++;
                    end
                end
                nb[r][c] = (n == 3) || (b[r][c] && n == 2);
            end
        end
        return nb;
    endfunction

    function automatic board_t rand_board();
        board_t b;
        for (int r = 0; r < N; r++) b[r] = row_t'($urandom);
        return b;
    endfunction

    task automatic load_board(input board_t b);
        @(negedge clk);
        userInput = b;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
        exp_w     = b;
        exp_f     = b;
        exp_gen   = '0;
    endtask

    // One step pulse, then enough cycles for the commit to be visible.
    task automatic do_step();
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (N + 2) @(negedge clk);
        exp_w   = model_gen(exp_w, 1'b1);
        exp_f   = model_gen(exp_f, 1'b0);
        exp_gen = exp_gen + 16'd1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        userInput = '0; load = 1'b0; run = 1'b0; step = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (board_w !== '0 || board_f !== '0) begin
            miscompares++;
            $display("FAIL reset_board: got %h / %h expected 0", board_w, board_f);
        end
        vectors++;
        if (gen_w !== 16'd0 || gen_f !== 16'd0 || busy_w !== 1'b0 || busy_f !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got gen %h/%h busy %b/%b expected 0", gen_w, gen_f, busy_w, busy_f);
        end
        // Asynchronous reset in the middle of a compute.
        load_board(rand_board());
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++;
        if (board_w !== '0 || busy_w !== 1'b0 || gen_w !== 16'd0 || busy_f !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_midcompute: got board %h busy %b gen %h", board_w, busy_w, gen_w);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (N + 4) @(negedge clk);
        vectors++;
        if (board_w !== '0 || gen_w !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_no_commit: got board %h gen %h expected 0", board_w, gen_w);
        end
    endtask

    task automatic test_blinker();
        board_t seed = '0;
        board_t vert = '0;
        int busy_cycles = 0;
        seed[7][6] = 1'b1; seed[7][7] = 1'b1; seed[7][8] = 1'b1;
        vert[6][7] = 1'b1; vert[7][7] = 1'b1; vert[8][7] = 1'b1;
        load_board(seed);
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
        for (int i = 0; i < N + 2; i++) begin
            if (busy_w) busy_cycles++;
            @(negedge clk);
        end
        exp_w = model_gen(exp_w, 1'b1);
        exp_f = model_gen(exp_f, 1'b0);
        exp_gen = 16'd1;
        vectors++;
        if (busy_cycles != N + 1) begin
            miscompares++;
            $display("FAIL blinker_busy_len: got %0d cycles expected %0d", busy_cycles, N + 1);
        end
        vectors++;
        if (board_w !== vert || board_f !== vert || board_w !== exp_w) begin
            miscompares++;
            $display("FAIL blinker_gen1: got %h expected %h", board_w, vert);
        end
        vectors++;
        if (gen_w !== 16'd1 || gen_f !== 16'd1) begin
            miscompares++;
            $display("FAIL blinker_count1: got %h expected 1", gen_w);
        end
        do_step();
        vectors++;
        if (board_w !== seed || board_f !== seed || gen_w !== 16'd2) begin
            miscompares++;
            $display("FAIL blinker_gen2: got %h gen %h expected %h gen 2", board_w, gen_w, seed);
        end
    endtask

    task automatic test_still_life();
        board_t seed = '0;
        seed[3][3] = 1'b1; seed[3][4] = 1'b1; seed[4][3] = 1'b1; seed[4][4] = 1'b1;
        load_board(seed);
        repeat (5) do_step();
        vectors++;
        if (board_w !== seed || board_f !== seed) begin
            miscompares++;
            $display("FAIL still_board: got %h / %h expected %h", board_w, board_f, seed);
        end
        vectors++;
        if (gen_w !== 16'd5 || gen_f !== exp_gen) begin
            miscompares++;
            $display("FAIL still_count: got %h expected 5", gen_w);
        end
    endtask

    task automatic test_edges();
        board_t seed = '0;
        board_t want_w = '0;
        board_t want_f = '0;
        seed[0][0] = 1'b1; seed[0][1] = 1'b1; seed[0][2] = 1'b1;
        want_w[15][1] = 1'b1; want_w[0][1] = 1'b1; want_w[1][1] = 1'b1;
        want_f[0][1] = 1'b1; want_f[1][1] = 1'b1;
        load_board(seed);
        do_step();
        vectors++;
        if (board_w !== want_w || board_w !== exp_w) begin
            miscompares++;
            $display("FAIL edge_wrap: got %h expected %h", board_w, want_w);
        end
        vectors++;
        if (board_f !== want_f || board_f !== exp_f) begin
            miscompares++;
            $display("FAIL edge_flat: got %h expected %h", board_f, want_f);
        end
    endtask

    task automatic test_glider();
        board_t seed = '0;
        seed[0][1] = 1'b1; seed[1][2] = 1'b1;
        seed[2][0] = 1'b1; seed[2][1] = 1'b1; seed[2][2] = 1'b1;
        load_board(seed);
        repeat (64) do_step();
        vectors++;
        if (board_w !== seed) begin
            miscompares++;
            $display("FAIL glider_torus: got %h expected %h", board_w, seed);
        end
        vectors++;
        if (board_f !== exp_f) begin
            miscompares++;
            $display("FAIL glider_flat: got %h expected %h", board_f, exp_f);
        end
        vectors++;
        if (gen_w !== 16'd64 || gen_f !== 16'd64) begin
            miscompares++;
            $display("FAIL glider_count: got %h / %h expected 64", gen_w, gen_f);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            int nsteps = $urandom_range(1, 4);
            load_board(rand_board());
            repeat (nsteps) do_step();
            vectors++;
            if (board_w !== exp_w || board_f !== exp_f || gen_w !== exp_gen) begin
                miscompares++;
                $display("FAIL random_%0d: got %h / %h gen %h expected %h / %h gen %h",
                         t, board_w, board_f, gen_w, exp_w, exp_f, exp_gen);
            end
        end
    endtask

    task automatic test_auto_run();
        logic [15:0] gen_at_drop;
        load_board(rand_board());
        run = 1'b1;
        repeat (110) @(negedge clk);
        run = 1'b0;
        repeat (N + 4) @(negedge clk);
        gen_at_drop = gen_w;
        repeat (30 - (N + 4)) @(negedge clk);
        repeat (110 / TDIV) begin
            exp_w = model_gen(exp_w, 1'b1);
            exp_f = model_gen(exp_f, 1'b0);
        end
        exp_gen = 16'(110 / TDIV);
        vectors++;
        if (gen_w !== exp_gen || gen_f !== exp_gen) begin
            miscompares++;
            $display("FAIL autorun_count: got %h / %h expected %h", gen_w, gen_f, exp_gen);
        end
        vectors++;
        if (gen_at_drop !== gen_w) begin
            miscompares++;
            $display("FAIL autorun_stop: got %h after idle expected %h", gen_w, gen_at_drop);
        end
        vectors++;
        if (board_w !== exp_w || board_f !== exp_f) begin
            miscompares++;
            $display("FAIL autorun_board: got %h / %h expected %h / %h", board_w, board_f, exp_w, exp_f);
        end
    endtask

    task automatic test_abort();
        board_t b2 = rand_board();
        load_board(rand_board());
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
        repeat (4) @(negedge clk);
        userInput = b2;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
        vectors++;
        if (board_w !== b2 || board_f !== b2 || gen_w !== 16'd0 || busy_w !== 1'b0 || busy_f !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_load: got %h gen %h busy %b expected %h gen 0 busy 0", board_w, gen_w, busy_w, b2);
        end
        userInput = ~b2;
        repeat (30) @(negedge clk);
        vectors++;
        if (board_w !== b2 || board_f !== b2 || gen_w !== 16'd0) begin
            miscompares++;
            $display("FAIL abort_no_commit: got %h gen %h expected %h gen 0", board_w, gen_w, b2);
        end
    endtask

    task automatic test_back_to_back();
        // step while busy is ignored
        load_board(rand_board());
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
        repeat (5) @(negedge clk);
        step = 1'b1;
        @(negedge clk); step = 1'b0;
        repeat (N + 4) @(negedge clk);
        exp_w = model_gen(exp_w, 1'b1);
        exp_f = model_gen(exp_f, 1'b0);
        vectors++;
        if (gen_w !== 16'd1 || board_w !== exp_w || board_f !== exp_f) begin
            miscompares++;
            $display("FAIL busy_step_ignored: got gen %h board %h expected gen 1 board %h", gen_w, board_w, exp_w);
        end
        // step coincident with the first tick: one generation only
        load_board(rand_board());
        run = 1'b1;
        repeat (TDIV - 1) @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        run  = 1'b0;
        repeat (N + 4) @(negedge clk);
        exp_w = model_gen(exp_w, 1'b1);
        exp_f = model_gen(exp_f, 1'b0);
        vectors++;
        if (gen_w !== 16'd1 || gen_f !== 16'd1 || board_w !== exp_w || board_f !== exp_f) begin
            miscompares++;
            $display("FAIL step_tick_merge: got gen %h / %h expected 1", gen_w, gen_f);
        end
    endtask

    initial begin
        test_reset();
        test_blinker();
        test_still_life();
        test_edges();
        test_glider();
        test_random();
        test_auto_run();
        test_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
